// File: rtl/zoned_security.sv
// Multi-zone security controller: key-switch arming, exit/entry countdowns, siren, first-zone latch and 2-digit display.
// Optional build macro SECURITY_SIREN_TIMEOUT_EN: ALARM falls back to ARMED after SIREN_SEC seconds.
module zoned_security #(
  parameter int               CLK_FREQ     = 125_000_000,
  parameter int               ZONES        = 2,
  parameter logic [ZONES-1:0] INSTANT_MASK = 2'b10,
  parameter int               EXIT_SEC     = 10,
  parameter int               ENTRY_SEC    = 5,
  parameter int               SIREN_SEC    = 30,
  parameter int               REFRESH_CYC  = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       KEY,
  input  logic [ZONES-1:0] SENSOR,
  output logic             ALARM_SIREN,
  output logic             CA,
  output logic [6:0]       AN
);

  localparam logic [2:0] ST_DISARMED = 3'd0;
  localparam logic [2:0] ST_EXIT     = 3'd1;
  localparam logic [2:0] ST_ARMED    = 3'd2;
  localparam logic [2:0] ST_ENTRY    = 3'd3;
  localparam logic [2:0] ST_ALARM    = 3'd4;

  localparam int MAX_A   = (EXIT_SEC > ENTRY_SEC) ? EXIT_SEC : ENTRY_SEC;
  localparam int MAX_SEC = (MAX_A > SIREN_SEC) ? MAX_A : SIREN_SEC;
  localparam int TICK_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int SEC_W   = $clog2(MAX_SEC + 1);
  localparam int REF_W   = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLK_FREQ - 1);
  localparam logic [SEC_W-1:0]  EXIT_LAST  = SEC_W'(EXIT_SEC - 1);
  localparam logic [SEC_W-1:0]  ENTRY_LAST = SEC_W'(ENTRY_SEC - 1);
  localparam logic [SEC_W-1:0]  SEC_SAT    = SEC_W'(MAX_SEC);
  localparam logic [REF_W-1:0]  REF_LAST   = REF_W'(REFRESH_CYC - 1);

  logic [2:0]        r_state;
  logic [TICK_W-1:0] r_tick;
  logic [SEC_W-1:0]  r_sec;
  logic [3:0]        r_zone;
  logic [REF_W-1:0]  r_ref;
  logic              r_ca;

  logic [2:0]  w_state_next;
  logic        w_wrap;
  logic        w_disarm;
  logic        w_arm;
  logic        w_inst;
  logic        w_del;
  logic [3:0]  w_first_zone;
  logic [31:0] w_remain;
  logic [3:0]  w_digit;
  logic        w_right_blank;
  logic [6:0]  w_left;
  logic [6:0]  w_right;

  assign w_wrap   = (r_tick == TICK_LAST);
  assign w_disarm = (KEY == 2'b00);
  assign w_arm    = (KEY == 2'b11);
  assign w_inst   = |(SENSOR & INSTANT_MASK);
  assign w_del    = |(SENSOR & ~INSTANT_MASK);

  always_comb begin
    w_first_zone = 4'd0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      if (SENSOR[i]) w_first_zone = 4'(i);
    end
  end

  // Disarm is checked first in every armed-side state so it beats any sensor event.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_DISARMED: if (w_arm) w_state_next = ST_EXIT;
      ST_EXIT: begin
        if (w_disarm)                        w_state_next = ST_DISARMED;
        else if (w_wrap && r_sec == EXIT_LAST) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_disarm)    w_state_next = ST_DISARMED;
        else if (w_inst) w_state_next = ST_ALARM;
        else if (w_del)  w_state_next = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (w_disarm)                           w_state_next = ST_DISARMED;
        else if (w_inst)                        w_state_next = ST_ALARM;
        else if (w_wrap && r_sec == ENTRY_LAST) w_state_next = ST_ALARM;
      end
      ST_ALARM: begin
        if (w_disarm) w_state_next = ST_DISARMED;
`ifdef SECURITY_SIREN_TIMEOUT_EN
        else if (w_wrap && r_sec == SEC_W'(SIREN_SEC - 1)) w_state_next = ST_ARMED;
`endif
      end
      default: w_state_next = ST_DISARMED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_DISARMED;
      r_tick  <= '0;
      r_sec   <= '0;
      r_zone  <= 4'd0;
      r_ref   <= '0;
      r_ca    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_tick <= '0;
        r_sec  <= '0;
      end else begin
        r_tick <= w_wrap ? '0 : r_tick + TICK_W'(1);
        // Saturate so long stays in ARMED/ALARM never wrap the seconds count.
        if (w_wrap && r_sec != SEC_SAT) r_sec <= r_sec + SEC_W'(1);
      end
      if (r_state == ST_ARMED && (w_state_next == ST_ENTRY || w_state_next == ST_ALARM))
        r_zone <= w_first_zone;
      else if (w_state_next == ST_DISARMED || w_state_next == ST_ARMED)
        r_zone <= 4'd0;
      if (r_ref == REF_LAST) begin
        r_ref <= '0;
        r_ca  <= ~r_ca;
      end else begin
        r_ref <= r_ref + REF_W'(1);
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    w_remain      = 32'd0;
    w_digit       = 4'd0;
    w_right_blank = 1'b1;
    w_left        = 7'b0111111;
    case (r_state)
      ST_EXIT: begin
        w_left        = 7'b0000110;
        w_remain      = 32'(EXIT_SEC) - 32'(r_sec);
        w_digit       = (w_remain > 32'd9) ? 4'd9 : w_remain[3:0];
        w_right_blank = 1'b0;
      end
      ST_ARMED: w_left = 7'b0001000;
      ST_ENTRY: begin
        w_left        = 7'b0100001;
        w_remain      = 32'(ENTRY_SEC) - 32'(r_sec);
        w_digit       = (w_remain > 32'd9) ? 4'd9 : w_remain[3:0];
        w_right_blank = 1'b0;
      end
      ST_ALARM: begin
        w_left        = 7'b0001110;
        w_digit       = r_zone;
        w_right_blank = 1'b0;
      end
      default: w_left = 7'b0111111;
    endcase
  end

  assign w_right     = w_right_blank ? 7'b1111111 : hex7(w_digit);
  assign AN          = r_ca ? w_left : w_right;
  assign CA          = r_ca;
  assign ALARM_SIREN = (r_state == ST_ALARM);

endmodule

// File: tb/tb_zoned_security.sv
// Bench for zoned_security: countdown sweeps, a vector table with an expected-result queue, and reset/timeout sequences.
module tb_zoned_security;
  localparam int         CLK_FREQ     = 100;
  localparam int         ZONES        = 3;
  localparam logic [2:0] INSTANT_MASK = 3'b110;
  localparam int         EXIT_SEC     = 2;
  localparam int         ENTRY_SEC    = 3;
  localparam int         SIREN_SEC    = 1;
  localparam int         REFRESH_CYC  = 4;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       key = 2'b01;
  logic [ZONES-1:0] sensor = '0;
  logic             siren;
  logic             ca;
  logic [6:0]       an;
  int               cyc;
  int               n_pass = 0;
  int               n_total = 0;

  always #5 clk = ~clk;

  // Reference model of the digit multiplexer phase: cycles since reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  zoned_security #(
    .CLK_FREQ(CLK_FREQ), .ZONES(ZONES), .INSTANT_MASK(INSTANT_MASK), .EXIT_SEC(EXIT_SEC),
    .ENTRY_SEC(ENTRY_SEC), .SIREN_SEC(SIREN_SEC), .REFRESH_CYC(REFRESH_CYC)
  ) dut (
    .CLK(clk), .RST(rst), .KEY(key), .SENSOR(sensor),
    .ALARM_SIREN(siren), .CA(ca), .AN(an)
  );

  typedef struct {
    logic [1:0] key;
    logic [2:0] sens;
    int         wait_cyc;
    logic       siren;
    logic [6:0] left;
    logic [6:0] right;
  } vec_t;

  typedef struct {
    int         idx;
    logic       siren;
    logic [6:0] left;
    logic [6:0] right;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];

  function automatic logic [6:0] hex7(input int d);
    case (d)
      0: hex7 = 7'b1000000;  1: hex7 = 7'b1111001;
      2: hex7 = 7'b0100100;  3: hex7 = 7'b0110000;
      default: hex7 = 7'b0000000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_cycle(input string name, input logic exp_siren,
                             input logic [6:0] l, input logic [6:0] r);
    logic exp_ca;
    exp_ca = ((cyc / REFRESH_CYC) % 2) == 1;
    check({name, "_siren"}, 32'(siren), 32'(exp_siren));
    check({name, "_ca"}, 32'(ca), 32'(exp_ca));
    check({name, "_an"}, 32'(an), 32'(exp_ca ? l : r));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_s;
    exp_t e;
    vecs[0] = '{2'b00, 3'b000, 0,   1'b0, SEG_DASH, SEG_BLANK};
    vecs[1] = '{2'b11, 3'b000, 200, 1'b0, SEG_A,    SEG_BLANK};
    vecs[2] = '{2'b01, 3'b100, 0,   1'b1, SEG_F,    hex7(2)};
    vecs[3] = '{2'b00, 3'b000, 0,   1'b0, SEG_DASH, SEG_BLANK};
    vecs[4] = '{2'b11, 3'b000, 200, 1'b0, SEG_A,    SEG_BLANK};
    vecs[5] = '{2'b00, 3'b010, 0,   1'b0, SEG_DASH, SEG_BLANK};
    vecs[6] = '{2'b11, 3'b000, 200, 1'b0, SEG_A,    SEG_BLANK};
    vecs[7] = '{2'b01, 3'b001, 0,   1'b0, SEG_D,    hex7(3)};
    vecs[8] = '{2'b01, 3'b010, 0,   1'b1, SEG_F,    hex7(0)};
`ifdef SECURITY_SIREN_TIMEOUT_EN
    vecs[9] = '{2'b01, 3'b000, 1000, 1'b0, SEG_A,   SEG_BLANK};
`else
    vecs[9] = '{2'b01, 3'b000, 1000, 1'b1, SEG_F,   hex7(0)};
`endif

    repeat (3) step();
    check("rst_siren", 32'(siren), 32'd0);
    check("rst_ca", 32'(ca), 32'd0);
    check("rst_an", 32'(an), 32'(SEG_BLANK));
    rst = 1'b0;
    step();
    check_cycle("disarmed", 1'b0, SEG_DASH, SEG_BLANK);

    // Arm, then sweep the whole exit delay cycle by cycle with a zone-0 pulse that must be ignored.
    key = 2'b11;
    step();
    key = 2'b01;
    for (int j = 0; j <= 200; j++) begin
      if (j < 200) check_cycle("exit", 1'b0, SEG_E, hex7(EXIT_SEC - j / CLK_FREQ));
      else         check_cycle("armed", 1'b0, SEG_A, SEG_BLANK);
      sensor = (j == 50) ? 3'b001 : 3'b000;
      if (j < 200) step();
    end
    sensor = '0;

    // Delayed zone pulse: full entry countdown, then ALARM showing zone 0.
    sensor = 3'b001;
    step();
    sensor = '0;
    for (int i = 0; i <= 300; i++) begin
      if (i < 300) check_cycle("entry", 1'b0, SEG_D, hex7(ENTRY_SEC - i / CLK_FREQ));
      else         check_cycle("alarm", 1'b1, SEG_F, hex7(0));
      if (i < 300) step();
    end

    for (int v = 0; v < 10; v++) begin
      key    = vecs[v].key;
      sensor = vecs[v].sens;
      sb_q.push_back('{v, vecs[v].siren, vecs[v].left, vecs[v].right});
      step();
      key    = 2'b01;
      sensor = '0;
      repeat (vecs[v].wait_cyc) step();
      e = sb_q.pop_front();
      for (int c = 0; c < 8; c++) begin
        check_cycle($sformatf("vec%0d", e.idx), e.siren, e.left, e.right);
        step();
      end
    end

    // Siren hold after an instant trip: timeout only when the feature is built in.
    key = 2'b00;
    step();
    key = 2'b11;
    step();
    key = 2'b01;
    repeat (200) step();
    sensor = 3'b100;
    step();
    sensor = '0;
    for (int i = 0; i <= 120; i++) begin
`ifdef SECURITY_SIREN_TIMEOUT_EN
      exp_s = (i < SIREN_SEC * CLK_FREQ);
`else
      exp_s = 1'b1;
`endif
      check("siren_hold", 32'(siren), 32'(exp_s));
      step();
    end

    sensor = 3'b100;
    step();
    sensor = '0;
    check("pre_rst_siren", 32'(siren), 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_siren", 32'(siren), 32'd0);
    check("mid_rst_ca", 32'(ca), 32'd0);
    check("mid_rst_an", 32'(an), 32'(SEG_BLANK));
    rst = 1'b0;
    step();
    check_cycle("post_rst", 1'b0, SEG_DASH, SEG_BLANK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/zoned_security.md
# zoned_security

Parametrised multi-zone security controller: arms and disarms from a two-bit key switch and watches `ZONES` sensor inputs, each either delayed (entry delay) or instant. It runs exit and entry countdowns, drives the siren and latches the first tripped zone. It also drives a two-digit multiplexed 7-segment display showing the state letter and either the countdown or the tripped-zone number. It sits at board top level between debounced switch/sensor inputs and the siren and display pins.

## Interface
- `CLK_FREQ`, 125_000_000: clock cycles per one-second tick.
- `ZONES`, 2: number of sensor zones, 1..10.
- `INSTANT_MASK`, 2'b10: `ZONES` bits; bit i = 1 makes zone i instant (no entry delay).
- `EXIT_SEC`, 10: exit delay in seconds, ≥1.
- `ENTRY_SEC`, 5: entry delay in seconds, ≥1.
- `SIREN_SEC`, 30: siren timeout in seconds; used only with the macro.
- `REFRESH_CYC`, 1000: cycles per display digit slot.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `KEY`  in  2: 2'b11 = arm request, 2'b00 = disarm, other values = no action.
- `SENSOR`  in  `ZONES`: level, 1 = zone open.
- `ALARM_SIREN`  out  1: siren drive.
- `CA`  out  1: digit select; 0 = right digit, 1 = left digit.
- `AN`  out  7: segments, active-low, bit order {g,f,e,d,c,b,a}.

## Operation
- States: DISARMED, EXIT, ARMED, ENTRY, ALARM.
- DISARMED → EXIT when `KEY`==11.
- EXIT → ARMED after `EXIT_SEC` seconds. `SENSOR` is ignored during EXIT.
- ARMED → ALARM if any instant zone is high. Otherwise ARMED → ENTRY if any delayed zone is high.
- ENTRY → ALARM after `ENTRY_SEC` seconds, or immediately when an instant zone goes high.
- Disarm priority: `KEY`==00 in EXIT, ARMED, ENTRY or ALARM → DISARMED. This takes priority over any simultaneous sensor event on the same edge.
- Zone latch: on the ARMED→ENTRY or ARMED→ALARM edge, store the index of the lowest-numbered high zone.
  - The latch holds until DISARMED. A later trip in ENTRY does not overwrite it.
- `ALARM_SIREN` = (state==ALARM), Moore decode.
- Second counter:
  - Counts 0..`CLK_FREQ`-1 and clears on every state change, so delays are exact.
  - Seconds-elapsed counter increments on wrap and clears on state change.
- Display:
  - `CA` toggles every `REFRESH_CYC` cycles.
  - Left digit (state letter): DISARMED '-'=0111111, EXIT 'E'=0000110, ARMED 'A'=0001000, ENTRY 'd'=0100001, ALARM 'F'=0001110.
  - Right digit in EXIT/ENTRY: remaining seconds (delay − elapsed), saturated at 9, standard hex encoding.
  - Right digit in ALARM: latched zone index.
  - Right digit otherwise: blank (1111111).

## Timing
- Reset: state DISARMED, all counters 0, latch 0, `CA`=0, `ALARM_SIREN`=0, `AN`=1111111.
- `RST` mid-operation returns to DISARMED on that edge, including from ALARM.
- Arm latency: `KEY`==11 sampled at edge k → EXIT from edge k.
- Exit delay: ARMED is entered exactly `EXIT_SEC`×`CLK_FREQ` edges after EXIT is entered.
- If a sensor is already high on entering ARMED, it trips on the next edge.
- Instant trip at edge k → `ALARM_SIREN` high in the cycle after edge k.
- Delayed trip at edge k → ENTRY. `ALARM_SIREN` rises `ENTRY_SEC`×`CLK_FREQ` edges later.
- Disarm at edge k → `ALARM_SIREN` low in the cycle after edge k.
- Countdown digit decrements at each second wrap; it shows `EXIT_SEC` or `ENTRY_SEC` (saturated at 9) in the first cycle of the state.
- Second counter widths are sized by $clog2 of `CLK_FREQ` and of the largest delay + 1. No wrap-around is possible within a state.

## Configuration
- `SECURITY_SIREN_TIMEOUT_EN` defined: after `SIREN_SEC` seconds in ALARM, go to ARMED and clear the latch. A zone still high re-trips per the ARMED rules.
- Undefined: ALARM holds until disarm or reset. `SIREN_SEC` is unused.

## Test plan
Bench parameters: `CLK_FREQ`=100, `ZONES`=3, `INSTANT_MASK`=3'b110, `EXIT_SEC`=2, `ENTRY_SEC`=3, `REFRESH_CYC`=4.
- Reset release, `KEY`=11 → EXIT; countdown digit 2 then 1; ARMED exactly 200 cycles later. `SENSOR`=001 pulsed during EXIT has no effect.
- Armed, `SENSOR[0]` one-cycle pulse → ENTRY; `ALARM_SIREN` rises 300 cycles later; ALARM right digit = 0.
- Armed, `SENSOR`=100 → siren next cycle; right digit 2. Then `KEY`=00 → siren low next cycle, display '-'/blank.
- In ENTRY, `SENSOR[1]` high → ALARM next edge; latch stays 0.
- `KEY`=00 and `SENSOR`=010 on the same edge in ARMED → DISARMED, no siren. `RST` during ALARM → all reset values.
- With the macro and `SIREN_SEC`=1: siren drops after 100 cycles, state ARMED. Without the macro: siren still high after 1000 cycles.
